// File: rtl/pci_arbiter_if.sv
// PCI arbitration bundle shared by the central arbiter and the bus controllers.
//   req         : per-master request, active-low (controller -> arbiter)
//   frame, irdy : bus control lines, active-low, observed by the arbiter
//   gnt         : per-master grant, active-low (arbiter -> controller)
//   owner       : index of the master currently granted or owning the bus
//   owner_valid : owner field is meaningful (grant offered or bus in use)
//   timeout     : one-cycle pulse when an unused grant is withdrawn
interface pci_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0] req;
    logic                   frame;
    logic                   irdy;
    logic [NUM_MASTERS-1:0] gnt;
    logic [1:0]             owner;
    logic                   owner_valid;
    logic                   timeout;

    modport slave (
        input  req,
        input  frame,
        input  irdy,
        output gnt,
        output owner,
        output owner_valid,
        output timeout
    );

    modport master (
        output req,
        output frame,
        output irdy,
        input  gnt,
        input  owner,
        input  owner_valid,
        input  timeout
    );
endinterface

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grant among up to four controllers,
// bus ownership tracked by snooping frame/irdy, unused grants withdrawn after
// GNT_TIMEOUT idle clocks. Never drives AD, C_BE, devsel or trdy.
//   clk   : bus clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : arbitration bundle (req/frame/irdy in, gnt/owner/owner_valid/timeout out)
module pci_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pci_arbiter_if.slave bus
);

    localparam int                TW         = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
    localparam logic [TW-1:0]     TIMER_LAST = TW'(GNT_TIMEOUT - 1);
    localparam logic [TW-1:0]     TIMER_MAX  = '1;
    localparam int unsigned       NM_U       = NUM_MASTERS;
    localparam logic [2:0]        NM3        = 3'(NUM_MASTERS);
    localparam logic [1:0]        LAST_RST   = 2'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ACTIVE,
        S_TURN
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [1:0]             owner_q, owner_d;
    logic [1:0]             last_q, last_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   timeout_q, timeout_d;

    // Requests widened to four active-high bits; absent masters never request.
    logic [3:0]             req_low;
    logic [2:0]             cand;
    logic [1:0]             winner;
    logic                   winner_found;
    logic                   bus_idle;
    logic                   owner_req;
    logic                   others_req;
    logic [3:0]             owner_oh4;

    assign req_low    = 4'(~bus.req);
    assign bus_idle   = bus.frame & bus.irdy;
    assign owner_oh4  = 4'b0001 << owner_q;
    assign owner_req  = req_low[owner_q];
    assign others_req = |(req_low & ~owner_oh4);

    // Rotating search starting just after the most recent grantee.
    always_comb begin
        winner       = last_q;
        winner_found = 1'b0;
        cand         = '0;
        for (int unsigned k = 1; k <= NM_U; k++) begin
            cand = {1'b0, last_q} + 3'(k);
            if (cand >= NM3) begin
                cand = cand - NM3;
            end
            if (!winner_found && req_low[cand[1:0]]) begin
                winner       = cand[1:0];
                winner_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '1;
            owner_q   <= '0;
            last_q    <= LAST_RST;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; frame beats withdrawal, which beats timeout.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (winner_found) begin
                    state_d = S_GRANT;
                    owner_d = winner;
                    last_d  = winner;
                    timer_d = '0;
                end
            end
            S_GRANT: begin
                if (!bus.frame) begin
                    state_d = S_ACTIVE;
                end else if (!owner_req) begin
                    state_d = S_TURN;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = S_TURN;
                    timeout_d = 1'b1;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (bus_idle) begin
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered grant vector, derived from the state being entered.
    // In ACTIVE the grant is sticky-high: once dropped it never returns.
    always_comb begin
        gnt_d = '1;
        unique case (state_d)
            S_GRANT: begin
                gnt_d = ~NUM_MASTERS'(4'b0001 << owner_d);
            end
            S_ACTIVE: begin
                if (!gnt_q[owner_q] && owner_req && !others_req) begin
                    gnt_d = ~NUM_MASTERS'(owner_oh4);
                end
            end
            default: begin
                gnt_d = '1;
            end
        endcase
    end

    assign bus.gnt         = gnt_q;
    assign bus.owner       = owner_q;
    assign bus.owner_valid = (state_q == S_GRANT) || (state_q == S_ACTIVE);
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_pci_arbiter.sv
module tb_pci_arbiter;

    localparam int N = 4;
    localparam int T = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pci_arbiter_if #(.NUM_MASTERS(N)) bus ();

    pci_arbiter #(
        .NUM_MASTERS(N),
        .GNT_TIMEOUT(T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: who holds the grant, whether the offer was taken up, and
    // whether a mandatory quiet clock is pending before the next offer.
    typedef struct {
        int holder;     // master whose gnt is low, -1 if none
        int owner;
        int last;
        int wait_cnt;   // idle clocks already spent on the current offer
        bit offered;    // grant offered, bus not yet taken
        bit inuse;      // offered master started a transaction
        bit gap;        // quiet clock before arbitration resumes
        bit to;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.holder   = -1;
        r.owner    = 0;
        r.last     = N - 1;
        r.wait_cnt = 0;
        r.offered  = 1'b0;
        r.inuse    = 1'b0;
        r.gap      = 1'b0;
        r.to       = 1'b0;
        return r;
    endfunction

    function automatic model_t model_next(model_t cur, logic [N-1:0] r, logic f, logic iv);
        model_t nx;
        int     others;
        bit     own_req;
        nx     = cur;
        nx.to  = 1'b0;
        others = 0;
        own_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!r[i] && i != cur.owner) others++;
            if (!r[i] && i == cur.owner) own_req = 1'b1;
        end
        if (cur.gap) begin
            nx.gap = 1'b0;
        end else if (cur.inuse) begin
            if (f && iv) begin
                nx.inuse  = 1'b0;
                nx.gap    = 1'b1;
                nx.holder = -1;
            end else if (!own_req || others > 0) begin
                nx.holder = -1;
            end
        end else if (cur.offered) begin
            if (!f) begin
                nx.offered = 1'b0;
                nx.inuse   = 1'b1;
                if (!own_req || others > 0) nx.holder = -1;
            end else if (!own_req) begin
                nx.offered = 1'b0;
                nx.gap     = 1'b1;
                nx.holder  = -1;
            end else if (cur.wait_cnt == T - 1) begin
                nx.offered = 1'b0;
                nx.gap     = 1'b1;
                nx.holder  = -1;
                nx.to      = 1'b1;
            end else begin
                nx.wait_cnt = cur.wait_cnt + 1;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (cur.last + k) % N;
                if (!r[idx]) begin
                    nx.holder   = idx;
                    nx.owner    = idx;
                    nx.last     = idx;
                    nx.wait_cnt = 0;
                    nx.offered  = 1'b1;
                    break;
                end
            end
        end
        return nx;
    endfunction

    function automatic logic [N-1:0] exp_gnt(int h);
        logic [N-1:0] v;
        v = '1;
        if (h >= 0) v[h] = 1'b0;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, bus.req, bus.frame, bus.irdy);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt", 32'(bus.gnt), 32'(exp_gnt(m.holder)));
            chk("owner", 32'(bus.owner), 32'(m.owner));
            chk("owner_valid", 32'(bus.owner_valid), 32'(m.offered || m.inuse));
            chk("timeout", 32'(bus.timeout), 32'(m.to));
            chk("gnt_onehot", 32'($countones(~bus.gnt) <= 1), 32'd1);
        end
    end

    // Drive inputs now (at a falling edge) and return at the next falling edge.
    task automatic cyc(input logic [N-1:0] r, input logic f, input logic i);
        bus.req   = r;
        bus.frame = f;
        bus.irdy  = i;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [N-1:0] rr_exp;
    logic [N-1:0] rq;
    logic         rf;
    logic         ri;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.req   = '1;
        bus.frame = 1'b1;
        bus.irdy  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_gnt", 32'(bus.gnt), 32'h0000_000F);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_owner_valid", 32'(bus.owner_valid), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);

        // Single requester
        cyc(4'b1101, 1'b1, 1'b1);
        chk("single_grant", 32'(bus.gnt), 32'b1101);
        chk("single_owner", 32'(bus.owner), 32'd1);
        cyc(4'b1101, 1'b1, 1'b1);
        repeat (3) cyc(4'b1101, 1'b0, 1'b0);
        chk("single_active_gnt", 32'(bus.gnt), 32'b1101);
        chk("single_active_valid", 32'(bus.owner_valid), 32'd1);
        cyc(4'b1101, 1'b1, 1'b1);
        chk("single_turn_gnt", 32'(bus.gnt), 32'hF);
        chk("single_turn_owner", 32'(bus.owner), 32'd1);
        cyc(4'b1101, 1'b1, 1'b1);
        chk("single_idle_gnt", 32'(bus.gnt), 32'hF);
        cyc(4'b1101, 1'b1, 1'b1);
        chk("single_regrant", 32'(bus.gnt), 32'b1101);

        // Withdrawal before frame
        cyc(4'b1111, 1'b1, 1'b1);
        chk("withdraw_gnt", 32'(bus.gnt), 32'hF);
        chk("withdraw_timeout", 32'(bus.timeout), 32'd0);
        cyc(4'b1111, 1'b1, 1'b1);

        // Round robin
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(4'b0000, 1'b1, 1'b1);
            rr_exp = ~(N'(1) << (k % N));
            chk("rr_grant", 32'(bus.gnt), 32'(rr_exp));
            chk("rr_owner", 32'(bus.owner), 32'(k % N));
            cyc(4'b0000, 1'b0, 1'b0);
            cyc(4'b0000, 1'b0, 1'b0);
            cyc(4'b0000, 1'b1, 1'b1);
            chk("rr_gap", 32'(bus.gnt), 32'hF);
            cyc(4'b0000, 1'b1, 1'b1);
        end

        // Preemption
        do_reset();
        cyc(4'b1011, 1'b1, 1'b1);
        chk("pre_grant", 32'(bus.gnt), 32'b1011);
        cyc(4'b1011, 1'b0, 1'b0);
        chk("pre_active", 32'(bus.gnt), 32'b1011);
        cyc(4'b1010, 1'b0, 1'b0);
        chk("pre_release", 32'(bus.gnt), 32'hF);
        chk("pre_owner", 32'(bus.owner), 32'd2);
        chk("pre_valid", 32'(bus.owner_valid), 32'd1);
        cyc(4'b1010, 1'b0, 1'b0);
        cyc(4'b1010, 1'b1, 1'b1);
        chk("pre_turn_owner", 32'(bus.owner), 32'd2);
        cyc(4'b1010, 1'b1, 1'b1);
        cyc(4'b1010, 1'b1, 1'b1);
        chk("pre_next_grant", 32'(bus.gnt), 32'b1110);
        chk("pre_next_owner", 32'(bus.owner), 32'd0);
        cyc(4'b1111, 1'b1, 1'b1);
        cyc(4'b1111, 1'b1, 1'b1);

        // Timeout: master 3 granted, never starts
        cyc(4'b0110, 1'b1, 1'b1);
        chk("to_grant", 32'(bus.gnt), 32'b0111);
        repeat (T - 1) cyc(4'b0110, 1'b1, 1'b1);
        chk("to_before_gnt", 32'(bus.gnt), 32'b0111);
        chk("to_before_pulse", 32'(bus.timeout), 32'd0);
        cyc(4'b0110, 1'b1, 1'b1);
        chk("to_gnt", 32'(bus.gnt), 32'hF);
        chk("to_pulse", 32'(bus.timeout), 32'd1);
        cyc(4'b0110, 1'b1, 1'b1);
        chk("to_pulse_end", 32'(bus.timeout), 32'd0);
        cyc(4'b0110, 1'b1, 1'b1);
        chk("to_next_grant", 32'(bus.gnt), 32'b1110);
        cyc(4'b1111, 1'b1, 1'b1);
        cyc(4'b1111, 1'b1, 1'b1);

        // Asynchronous reset in ACTIVE
        cyc(4'b1101, 1'b1, 1'b1);
        chk("ar_grant", 32'(bus.gnt), 32'b1101);
        cyc(4'b1101, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt_now", 32'(bus.gnt), 32'hF);
        chk("ar_valid_now", 32'(bus.owner_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b0000, 1'b1, 1'b1);
        chk("ar_first_winner", 32'(bus.gnt), 32'b1110);
        cyc(4'b1111, 1'b1, 1'b1);
        cyc(4'b1111, 1'b1, 1'b1);

        // Randomized traffic
        rq = '1;
        for (int seg = 0; seg < 30; seg++) begin
            int mode;
            int len;
            mode = int'($urandom_range(0, 2));
            len  = int'($urandom_range(20, 120));
            if (seg == 15) begin
                #3;
                rst_n = 1'b0;
                #1;
                chk("rand_ar_gnt", 32'(bus.gnt), 32'hF);
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int c = 0; c < len; c++) begin
                for (int b = 0; b < N; b++) begin
                    if (rq[b]) begin
                        if ($urandom_range(0, 7) == 0) rq[b] = 1'b0;
                    end else begin
                        if (mode == 1) begin
                            if ($urandom_range(0, 39) == 0) rq[b] = 1'b1;
                        end else if ($urandom_range(0, 5) == 0) begin
                            rq[b] = 1'b1;
                        end
                    end
                end
                case (mode)
                    0:       rf = ($urandom_range(0, 9) >= 4);
                    1:       rf = 1'b1;
                    default: rf = ($urandom_range(0, 9) >= 8);
                endcase
                ri = rf ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
                cyc(rq, rf, ri);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pci_arbiter.md
# pci_arbiter

Central PCI bus arbiter that answers the `req`/`gnt` handshake of up to four bus controllers, granting the shared AD/C_BE/frame/irdy bus to one initiator at a time. It is the responder side of each controller's arbitration interface. It sits at system level beside the bus, snoops `frame` and `irdy` to track bus ownership, and uses rotating (round-robin) priority with a grant timeout. It never drives AD, C_BE, devsel or trdy.

## Interface
- NUM_MASTERS, 4, number of requesting controllers (2..4; index = device address)
- GNT_TIMEOUT, 16, idle bus clocks a granted master may take to assert `frame` before its grant is withdrawn
- clk  input  1  bus clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_MASTERS  per-master request, active-low
- frame  input  1  bus frame, active-low, snooped only
- irdy  input  1  bus irdy, active-low, snooped only
- gnt  output  NUM_MASTERS  per-master grant, active-low, registered, at most one low
- owner  output  2  index of the master currently granted or owning the bus
- owner_valid  output  1  high in GRANT and ACTIVE
- timeout  output  1  one-cycle pulse when a grant is withdrawn for timeout

## Operation
- Bus idle = `frame`==1 and `irdy`==1 sampled on the same edge.
- Pointer `last` holds the most recently granted index. The search order is last+1, last+2, … mod NUM_MASTERS. The first index with `req` low wins.
- States:
  - IDLE:
    - All `gnt` high.
    - If any `req` is low: select the winner, drive its `gnt` low, set owner and last to the winner, clear the timer, go to GRANT.
  - GRANT:
    - `gnt[owner]` low.
    - If `frame`==0: go to ACTIVE.
    - Else if `req[owner]`==1 (request withdrawn): go to TURN.
    - Else: timer++.
    - When the timer reaches GNT_TIMEOUT-1 without `frame`: pulse `timeout`, go to TURN.
  - ACTIVE:
    - `gnt[owner]` stays low while `req[owner]`==0 and no other `req` is low.
    - Once either condition fails, `gnt[owner]` goes high and stays high until the end of the state. The master's own latency timer governs release.
    - On bus idle: go to TURN.
  - TURN:
    - All `gnt` high for exactly one clock, then go to IDLE.
    - This guarantees one all-deasserted cycle between any two grants.
- The timer is ceil(log2(GNT_TIMEOUT)) bits wide and saturates. It counts only in GRANT.
- No bus parking: with no requests, all `gnt` are high.

## Timing
- Reset (asynchronous, immediate):
  - gnt = all 1
  - state = IDLE
  - last = NUM_MASTERS-1 (master 0 has first priority)
  - owner = 0
  - owner_valid = 0
  - timeout = 0
  - timer = 0
- Reset asserted mid-transaction releases every grant at once, without waiting for the bus to go idle.
- Grant latency:
  - `req` sampled low at edge N in IDLE gives `gnt` low after edge N.
  - Minimum re-grant spacing: ACTIVE→TURN→IDLE→GRANT gives the next grant 3 edges after bus idle is sampled.
- Simultaneous requests are resolved by rotating order only.
- A `req` that deasserts on the same edge it would win is not granted, because it is sampled high.
- GRANT with `frame`==0 and `req[owner]`==1 on the same edge goes to ACTIVE, because `frame` has priority.
- Timeout has the lowest priority in GRANT.
- `owner` is held unchanged through TURN and IDLE until the next grant.
- `timeout` is high for exactly the one cycle following the withdrawing edge.

## Test plan
- Single requester:
  - Stimulus: reset; `req`=4'b1101. Hold `frame` high for 2 clocks, drop `frame` for 3 clocks, then bus idle.
  - Required response: `gnt`=4'b1101 the cycle after the first sampled req. Then ACTIVE. Then `gnt`=4'b1111 for one TURN cycle. Then re-granted to master 1 if still requesting.
- Round robin:
  - Stimulus: `req`=4'b0000 held. Each grantee runs a 2-cycle frame.
  - Required response: grant order is 0,1,2,3,0. Every handover shows one all-high `gnt` cycle.
- Preemption:
  - Stimulus: master 2 in ACTIVE; master 0 asserts `req`.
  - Required response: `gnt[2]` goes high on the next edge. `owner` stays 2 until bus idle. Master 0 is granted after TURN.
- Timeout:
  - Stimulus: grant master 3; never assert `frame`.
  - Required response: `timeout` pulses and `gnt[3]` rises exactly 16 clocks after grant. The next grant goes to another requester (master 0 if requesting).
- Withdrawal:
  - Stimulus: master 1 granted, then drops `req` before `frame`.
  - Required response: grant released next edge, no `timeout` pulse.
- Async reset:
  - Stimulus: assert `rst_n`=0 mid-ACTIVE between clock edges.
  - Required response: `gnt`=4'b1111 and `owner_valid`=0 immediately. After release, master 0 wins first.
